// File: rtl/word_pkg.sv
// Shared definitions for the word picker: letter codes, FSM states,
// LFSR constants and the per-difficulty word tables.
package word_pkg;

    // Letter codes: A=1 .. Z=26, 0 is never a valid letter.
    typedef enum logic [4:0] {
        L_NONE = 5'd0,
        L_A = 5'd1, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
        L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z
    } letter_e;

    // Picker control states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_CHECK,
        ST_LOAD
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in a left-shifting Fibonacci register:
    // feedback taps on bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Dimensions of the stored word tables.
    localparam int TBL_BANKS = 3;
    localparam int TBL_WORDS = 8;
    localparam int TBL_LEN   = 5;

    // Word tables indexed [bank][word][letter]; letter 0 is the first letter.
    localparam letter_e WORD_TABLE [TBL_BANKS][TBL_WORDS][TBL_LEN] = '{
        // bank 0: easy
        '{ '{L_A, L_P, L_P, L_L, L_E}, '{L_B, L_R, L_E, L_A, L_D},
           '{L_C, L_H, L_A, L_I, L_R}, '{L_D, L_A, L_N, L_C, L_E},
           '{L_E, L_A, L_G, L_L, L_E}, '{L_F, L_L, L_A, L_M, L_E},
           '{L_G, L_R, L_A, L_P, L_E}, '{L_H, L_O, L_U, L_S, L_E} },
        // bank 1: medium
        '{ '{L_M, L_A, L_P, L_L, L_E}, '{L_Q, L_U, L_A, L_R, L_T},
           '{L_T, L_A, L_B, L_L, L_E}, '{L_B, L_A, L_N, L_J, L_O},
           '{L_C, L_L, L_O, L_A, L_K}, '{L_D, L_W, L_A, L_R, L_F},
           '{L_E, L_P, L_O, L_X, L_Y}, '{L_F, L_J, L_O, L_R, L_D} },
        // bank 2: hard
        '{ '{L_J, L_A, L_Z, L_Z, L_Y}, '{L_F, L_U, L_Z, L_Z, L_Y},
           '{L_Q, L_U, L_I, L_R, L_K}, '{L_G, L_L, L_Y, L_P, L_H},
           '{L_N, L_Y, L_M, L_P, L_H}, '{L_C, L_R, L_Y, L_P, L_T},
           '{L_P, L_I, L_X, L_E, L_L}, '{L_K, L_A, L_Y, L_A, L_K} }
    };

    // Table lookup with a safe fallback ('A') outside the stored tables,
    // so larger parameterisations still elaborate to defined letters.
    function automatic logic [4:0] letter_at(int bank, int word, int pos);
        if (bank >= 0 && bank < TBL_BANKS && word >= 0 && word < TBL_WORDS &&
            pos >= 0 && pos < TBL_LEN)
            return WORD_TABLE[bank[1:0]][word[2:0]][pos[2:0]];
        return L_A;
    endfunction

endpackage

// File: rtl/word_picker_lfsr16.sv
// Free-running 16-bit maximal-length LFSR; the all-zero state is never
// reachable from the non-zero seed.
module lfsr16
    import word_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] value
);

    // Shift left every cycle, feeding back the XOR of the tap bits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= LFSR_SEED;
        else
            value <= {value[14:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/word_picker.sv
// Random word picker: draws an index from the LFSR, rejects indices recently
// used in the selected difficulty bank (bounded retries), then loads the word.
module word_picker
    import word_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int LETTER_W   = 5,
    parameter int NUM_WORDS  = 8,
    parameter int NUM_BANKS  = 3,
    parameter int HIST_DEPTH = 4,
    parameter int MAX_RETRY  = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         new_game,
    input  logic [1:0]                   difficulty,
    input  logic                         hist_clr,
    output logic [WORD_LEN*LETTER_W-1:0] encoded_word,
    output logic [$clog2(NUM_WORDS)-1:0] word_id,
    output logic                         word_valid,
    output logic                         busy
);

    localparam int IDX_W   = $clog2(NUM_WORDS);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef logic [WORD_LEN*LETTER_W-1:0] word_t;

    // "AAA..." : every letter position holds code 1.
    localparam word_t RESET_WORD = {WORD_LEN{LETTER_W'(1)}};

    state_t              state;
    logic [1:0]          bank_q;
    logic [IDX_W-1:0]    cand_q;
    logic [RETRY_W-1:0]  retry_q;
    logic [15:0]         lfsr_value;
    logic [1:0]          bank_sel;
    logic                hist_hit;
    logic                push;

    // Per-bank recent-pick FIFO: entry 0 is the newest.
    logic [HIST_DEPTH-1:0] hist_vld [NUM_BANKS];
    logic [IDX_W-1:0]      hist_idx [NUM_BANKS][HIST_DEPTH];

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_value)
    );

    // Only the low index bits of the LFSR take part in a draw.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_value[15:IDX_W];

    // Combinational ROM, built from the package tables at elaboration.
    function automatic word_t rom_word(int bank, int idx);
        word_t w;
        w = '0;
        for (int k = 0; k < WORD_LEN; k++)
            w[(WORD_LEN-1-k)*LETTER_W +: LETTER_W] = LETTER_W'(letter_at(bank, idx, k));
        return w;
    endfunction

    word_t rom [NUM_BANKS][NUM_WORDS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_rom_bank
        for (genvar w = 0; w < NUM_WORDS; w++) begin : g_rom_word
            assign rom[b][w] = rom_word(b, w);
        end
    end

    // Out-of-range difficulty selects the hardest bank.
    always_comb begin
        bank_sel = (int'(difficulty) >= NUM_BANKS) ? 2'(NUM_BANKS - 1) : difficulty;
    end

    // Candidate hits a valid history entry of the latched bank; a concurrent
    // clear empties the history, so it also suppresses the hit.
    // NOTE: hist_hit gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        hist_hit = 1'b0;
        for (int d = 0; d < HIST_DEPTH; d++)
            if (hist_vld[bank_q][d] && (hist_idx[bank_q][d] == cand_q))
                hist_hit = 1'b1;
        if (hist_clr)
            hist_hit = 1'b0;
    end

    assign push = (state == ST_LOAD) && !hist_clr;

    // History valid bits: reset/clear invalidate everything; a push shifts
    // the latched bank's FIFO, dropping the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                hist_vld[b] <= '0;
        end else if (hist_clr) begin
            for (int b = 0; b < NUM_BANKS; b++)
                hist_vld[b] <= '0;
        end else if (push) begin
            for (int d = HIST_DEPTH - 1; d > 0; d--)
                hist_vld[bank_q][d] <= hist_vld[bank_q][d-1];
            hist_vld[bank_q][0] <= 1'b1;
        end
    end

    // History indices shift alongside their valid bits.
    // NOTE: this storage has no reset; an entry is only ever read when its
    // valid bit is set, so the reset-qualified valid bits are sufficient.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int d = HIST_DEPTH - 1; d > 0; d--)
                hist_idx[bank_q][d] <= hist_idx[bank_q][d-1];
            hist_idx[bank_q][0] <= cand_q;
        end
    end

    // Pick sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bank_q       <= '0;
            cand_q       <= '0;
            retry_q      <= '0;
            encoded_word <= RESET_WORD;
            word_id      <= '0;
            word_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_game) begin
                        bank_q     <= bank_sel;
                        retry_q    <= '0;
                        busy       <= 1'b1;
                        word_valid <= 1'b0;
                        state      <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    cand_q <= lfsr_value[IDX_W-1:0];
                    state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hist_hit && (retry_q < RETRY_W'(MAX_RETRY))) begin
                        retry_q <= retry_q + RETRY_W'(1);
                        state   <= ST_DRAW;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    encoded_word <= rom[bank_q][cand_q];
                    word_id      <= cand_q;
                    word_valid   <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_picker.sv
// Scoreboard bench for word_picker: each request pushes its predicted word,
// id and completion cycle; a monitor pops and compares on each word_valid rise.
module tb_word_picker;

    localparam int SEQ_N = 12000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic [1:0]  difficulty = 2'd0;
    logic        hist_clr = 1'b0;
    logic [24:0] encoded_word;
    logic [2:0]  word_id;
    logic        word_valid;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc;
    int last_idx = 0;

    always #5 clk = ~clk;

    word_picker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_game     (new_game),
        .difficulty   (difficulty),
        .hist_clr     (hist_clr),
        .encoded_word (encoded_word),
        .word_id      (word_id),
        .word_valid   (word_valid),
        .busy         (busy)
    );

    // Rising edges since reset release; equals the number of LFSR steps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Hand-written word lists, [bank][index].
    string names [3][8] = '{
        '{"APPLE", "BREAD", "CHAIR", "DANCE", "EAGLE", "FLAME", "GRAPE", "HOUSE"},
        '{"MAPLE", "QUART", "TABLE", "BANJO", "CLOAK", "DWARF", "EPOXY", "FJORD"},
        '{"JAZZY", "FUZZY", "QUIRK", "GLYPH", "NYMPH", "CRYPT", "PIXEL", "KAYAK"}
    };

    function automatic logic [24:0] enc(string s);
        logic [24:0] r;
        r = '0;
        for (int k = 0; k < 5; k++)
            r[(4-k)*5 +: 5] = 5'(s[k] - 8'd64);
        return r;
    endfunction

    // Reference LFSR sequence: seq[n] is the register after n steps.
    logic [15:0] seq [SEQ_N];

    // Reference history: per bank, up to 4 recent ids, newest last.
    int hist [3][4];
    int hcnt [3];

    function automatic bit in_hist(int b, int c);
        for (int i = 0; i < hcnt[b]; i++)
            if (hist[b][i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void push_hist(int b, int c);
        if (hcnt[b] == 4) begin
            for (int i = 0; i < 3; i++) hist[b][i] = hist[b][i+1];
            hist[b][3] = c;
        end else begin
            hist[b][hcnt[b]] = c;
            hcnt[b] = hcnt[b] + 1;
        end
    endfunction

    function automatic void clear_hist();
        for (int b = 0; b < 3; b++) hcnt[b] = 0;
    endfunction

    // Draws for a request whose first DRAW samples seq[j]; hits counts
    // consecutive history hits, 8 meaning the forced accept after 7 retries.
    function automatic void simulate(input int j, input int b, output int hits, output int idx);
        int r;
        r = 0;
        hits = 0;
        idx = 0;
        forever begin
            idx = int'(seq[j + 2*r][2:0]);
            if (!in_hist(b, idx)) begin hits = r; break; end
            if (r == 7) begin hits = 8; break; end
            r++;
        end
    endfunction

    typedef struct {
        logic [24:0] word;
        logic [2:0]  id;
        int          due;
    } exp_t;

    exp_t sbq [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed pick against the scoreboard head.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (word_valid && !prev_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: word 0x%0h id %0d with no pending request", encoded_word, word_id);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("word", 32'(encoded_word), 32'(e.word));
                check("word_id", 32'(word_id), 32'(e.id));
                check("valid_cycle", cyc, e.due);
            end
        end
        prev_valid <= word_valid;
    end

    // opt: 0 plain, 1 pulse new_game/toggle difficulty while busy,
    //      2 hist_clr on the LOAD edge, 3 reset during DRAW.
    task automatic issue(input int diff, input int want_hits, input int target, input int opt);
        int   b, j, hits, idx, lat, count, guard;
        bit   found;
        exp_t e;
        b = (diff > 2) ? 2 : diff;
        found = 1'b0;
        hits = 0;
        idx = 0;
        @(negedge clk);
        for (j = cyc + 1; j < SEQ_N - 20; j++) begin
            simulate(j, b, hits, idx);
            if ((want_hits < 0 || hits == want_hits) && (target < 0 || idx == target)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL search: no LFSR window for bank %0d hits %0d target %0d", b, want_hits, target);
            return;
        end
        while (cyc + 1 < j) @(negedge clk);
        new_game = 1'b1;
        difficulty = diff[1:0];
        lat = 3 + 2 * ((hits > 7) ? 7 : hits);
        e.word = enc(names[b][idx]);
        e.id = idx[2:0];
        e.due = cyc + 1 + lat;
        sbq.push_back(e);
        last_idx = idx;
        if (opt == 2 || opt == 3) clear_hist();
        else push_hist(b, idx);
        @(negedge clk);
        new_game = 1'b0;
        count = 0;
        for (guard = 0; guard < 100; guard++) begin
            if (opt == 3) begin
                rst_n = 1'b0;
                #1;
                check("abort_word", 32'(encoded_word), 32'(enc("AAAAA")));
                check("abort_valid", 32'(word_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                void'(sbq.pop_back());
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (word_valid) break;
            if (busy) count++;
            if (opt == 1) begin
                new_game = (count == 1);
                difficulty = difficulty ^ 2'b01;
            end
            if (opt == 2) hist_clr = (count == lat);
            @(negedge clk);
        end
        new_game = 1'b0;
        hist_clr = 1'b0;
        if (guard == 100) begin
            tests++;
            fails++;
            $display("FAIL timeout: word_valid not seen within 100 cycles");
        end
        check("busy_cycles", count, lat);
        check("busy_low_after", 32'(busy), 32'd0);
    endtask

    initial begin
        seq[0] = 16'hACE1;
        for (int i = 1; i < SEQ_N; i++)
            seq[i] = {seq[i-1][14:0], seq[i-1][15] ^ seq[i-1][13] ^ seq[i-1][12] ^ seq[i-1][10]};
        clear_hist();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_word", 32'(encoded_word), 32'(enc("AAAAA")));
        check("rst_word_id", 32'(word_id), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Medium bank, index 2 -> TABLE.
        issue(1, 0, 2, 0);

        // Four fresh picks from bank 0, then one forced repeat (one retry).
        for (int i = 0; i < 4; i++) issue(0, 0, -1, 0);
        issue(0, 1, -1, 0);

        // History full; eight hits in a row -> forced accept, 17 cycles.
        issue(0, 8, -1, 0);

        // difficulty=3 clamps to bank 2; mid-pick new_game and difficulty
        // changes must not produce a second pick.
        issue(3, -1, -1, 1);
        repeat (6) @(negedge clk);
        check("no_extra_pick", sbq.size(), 0);

        // hist_clr on the LOAD edge drops the push; the same id is then
        // accepted on its first draw.
        issue(0, -1, -1, 2);
        issue(0, 0, last_idx, 0);

        // Reset during DRAW aborts; history is gone, latency is 3 again.
        issue(0, -1, -1, 3);
        issue(0, 0, last_idx, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/word_picker.md
WORD_PICKER -- requirements
Module: word_picker

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, letters per word.
REQ-002 SHALL have parameter LETTER_W, default 5, bits per letter code (A=1 .. Z=26, 0 unused).
REQ-003 SHALL have parameter NUM_WORDS, default 8, words per bank; a power of two, 2..64.
REQ-004 SHALL have parameter NUM_BANKS, default 3, difficulty banks (0 easy, 1 medium, 2 hard).
REQ-005 SHALL have parameter HIST_DEPTH, default 4, recent picks remembered per bank; 1..NUM_WORDS-1.
REQ-006 SHALL have parameter MAX_RETRY, default 7, redraws allowed before forced accept.
REQ-007 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 SHALL have port new_game  input  1  one-cycle request for a new word.
REQ-010 SHALL have port difficulty  input  2  bank select, sampled on an accepted new_game.
REQ-011 SHALL have port hist_clr  input  1  clears the history of all banks.
REQ-012 SHALL have port encoded_word  output  WORD_LEN*LETTER_W  picked word; first letter in the MSBs.
REQ-013 SHALL have port word_id  output  clog2(NUM_WORDS)  index of the picked word within its bank.
REQ-014 SHALL have port word_valid  output  1  high while encoded_word holds a completed pick.
REQ-015 SHALL have port busy  output  1  high from request acceptance until the pick completes.

Function
REQ-016 SHALL run a free-running 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1, advancing every cycle, never reaching zero.
REQ-017 SHALL implement FSM IDLE -> DRAW -> CHECK -> LOAD -> IDLE, with CHECK -> DRAW on a history hit while retry count < MAX_RETRY.
REQ-018 IDLE: new_game=1 SHALL latch the bank, clear the retry counter, assert busy, deassert word_valid, and enter DRAW.
REQ-019 Bank latch: difficulty >= NUM_BANKS SHALL clamp to NUM_BANKS-1; later difficulty changes SHALL be ignored until the next accepted request.
REQ-020 DRAW SHALL register candidate = LFSR[clog2(NUM_WORDS)-1:0].
REQ-021 CHECK SHALL compare the candidate against the valid history entries of the latched bank; on a hit with retry < MAX_RETRY it SHALL increment retry and return to DRAW.
REQ-022 Forced accept: on a hit with retry = MAX_RETRY, the candidate SHALL be accepted unchanged.
REQ-023 LOAD SHALL register the ROM word and word_id, push the candidate into the bank's history (FIFO, oldest dropped when full), set word_valid=1, clear busy, and return to IDLE.
REQ-024 Latency: with no history hit, word_valid SHALL rise 3 cycles after the new_game edge; each retry SHALL add 2 cycles.
REQ-025 new_game while busy SHALL be ignored; new_game in IDLE while word_valid=1 SHALL start a new pick.
REQ-026 hist_clr SHALL invalidate all history entries next cycle in any state; with a simultaneous CHECK or push, the clear SHALL win and the push SHALL be dropped.
REQ-027 encoded_word and word_id SHALL hold their values until the next LOAD or reset.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, encoded_word to all letter codes = 1 ("AAAAA"), word_id=0, word_valid=0, busy=0, LFSR=16'hACE1, history invalid, retry=0.
REQ-029 Reset mid-pick SHALL abort the pick with no history update; the first request after release SHALL behave per REQ-024.

Structure
REQ-030 Shared package word_pkg SHALL hold the letter-code constants, the FSM state enum, the LFSR seed/taps, and per-bank word tables as constant arrays indexed [bank][word].
REQ-031 The LFSR SHALL be a separate sub-module lfsr16 (clk, rst_n, value); the table lookup SHALL be a combinational ROM in word_picker.

Verification
REQ-032 Reset: rst_n low mid-DRAW -> same cycle encoded_word=5x5'd1, word_valid=0, busy=0; after release, new_game -> word_valid at cycle +3.
REQ-033 Bank select: difficulty=1 with LFSR forced so the index is 2 -> encoded_word = TABLE (20,1,2,12,5), word_id=2.
REQ-034 No-repeat: 4 picks from bank 0 with hist_clr between none -> all word_id distinct; a repeat forced via the LFSR -> 2-cycle retry, busy stays high.
REQ-035 Forced accept: history full and the LFSR forced to a history index for 8 draws -> accept after MAX_RETRY, latency 3+2*7=17 cycles.
REQ-036 Clamp/ignore: difficulty=3 -> bank 2 word; new_game pulsed while busy -> exactly one word_valid rise; difficulty toggled mid-pick -> no effect.
REQ-037 hist_clr asserted in the same cycle as LOAD -> history empty afterwards; the next pick may return the same word_id.
